// File: rtl/prio_encoder_rr.sv
// Registered N-way priority encoder with fixed (highest index wins) or
// round-robin arbitration and valid/ready handshakes on both sides.
module prio_encoder_rr #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic         any
);

  localparam logic [W-1:0] PTR_RST = W'(N - 1);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] grant_q, grant_d;
  logic         any_q, any_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic         hit;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic         rr_hit;
  logic [W-1:0] pos;
  logic [W-1:0] win;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign hit      = |req;

  // Both searches run in parallel; mode selects the winner afterwards.
  always_comb begin
    fix_idx = '0;
    rr_idx  = '0;
    rr_hit  = 1'b0;
    pos     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) fix_idx = W'(i);
    end
    // Walk downward from ptr, wrapping from 0 to N-1; first hit wins.
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(ptr_q) >= k) pos = W'(32'(ptr_q) - k);
      else                 pos = W'(32'(ptr_q) + N - k);
      if (!rr_hit && req[pos]) begin
        rr_hit = 1'b1;
        rr_idx = pos;
      end
    end
    win = mode ? rr_idx : fix_idx;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    grant_d     = grant_q;
    any_d       = any_q;
    ptr_d       = ptr_q;
    if (out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      any_d       = hit;
      idx_d       = hit ? win : '0;
      grant_d     = hit ? (N'(1) << win) : '0;
      // The granted line drops to lowest priority for the next round.
      if (mode && hit) ptr_d = (win == '0) ? PTR_RST : win - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      grant_q     <= '0;
      any_q       <= 1'b0;
      ptr_q       <= PTR_RST;
    end else begin
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      grant_q     <= grant_d;
      any_q       <= any_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign idx       = idx_q;
  assign grant     = grant_q;
  assign any       = any_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: an N=8 and an N=5 instance, directed
// scenarios followed by random traffic, checked against a distance-based model.
module tb_prio_encoder_rr;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] grant;
    logic       any;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] req8;  logic mode8, iv8, ir8, ov8, or8, any8;
  logic [2:0] idx8;  logic [7:0] grant8;
  logic [4:0] req5;  logic mode5, iv5, ir5, ov5, or5, any5;
  logic [2:0] idx5;  logic [4:0] grant5;

  prio_encoder_rr #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode8), .in_valid(iv8),
    .in_ready(ir8), .out_valid(ov8), .out_ready(or8), .idx(idx8),
    .grant(grant8), .any(any8)
  );

  prio_encoder_rr #(.N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode5), .in_valid(iv5),
    .in_ready(ir5), .out_valid(ov5), .out_ready(or5), .idx(idx5),
    .grant(grant5), .any(any5)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q8[$];
  exp_t q5[$];
  int   ptr8 = 7;
  int   ptr5 = 4;

  // Fixed: highest set index. Round-robin: the set index closest below ptr
  // in circular distance wins, then ptr moves just below the winner.
  function automatic exp_t model(input int n, input logic [7:0] r, input logic m,
                                 input int ptr, output int nptr);
    exp_t e;
    int   best;
    int   bestd;
    e     = '0;
    best  = -1;
    bestd = n;
    nptr  = ptr;
    for (int i = 0; i < n; i++) begin
      if (r[i]) begin
        if (!m) best = i;
        else if (((ptr - i + n) % n) < bestd) begin
          bestd = (ptr - i + n) % n;
          best  = i;
        end
      end
    end
    if (best >= 0) begin
      e.any   = 1'b1;
      e.idx   = 3'(best);
      e.grant = 8'(1) << best;
      if (m) nptr = (best == 0) ? n - 1 : best - 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req_v);
    n_cmp++;
    if (act != req_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic chk_res(input string name, input logic [2:0] i, input logic [7:0] g,
                         input logic a, input exp_t e);
    n_cmp++;
    if (i !== e.idx || g !== e.grant || a !== e.any) begin
      n_bad++;
      $display("FAIL %s: got idx=%0d grant=%h any=%0d, required idx=%0d grant=%h any=%0d at %0t",
               name, i, g, a, e.idx, e.grant, e.any, $time);
    end
  endtask

  // Monitors: check handshake and held result, pop on consume, push on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      logic acc;
      exp_t e;
      int   np;
      acc = iv8 && (q8.size() == 0 || or8);
      chk("in_ready8", int'(ir8), int'(q8.size() == 0 || or8));
      chk("out_valid8", int'(ov8), int'(q8.size() != 0));
      if (ov8 && q8.size() != 0) begin
        chk_res("result8", idx8, grant8, any8, q8[0]);
        if (or8) void'(q8.pop_front());
      end
      if (acc) begin
        e = model(8, req8, mode8, ptr8, np);
        ptr8 = np;
        q8.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic acc;
      exp_t e;
      int   np;
      acc = iv5 && (q5.size() == 0 || or5);
      chk("in_ready5", int'(ir5), int'(q5.size() == 0 || or5));
      chk("out_valid5", int'(ov5), int'(q5.size() != 0));
      if (ov5 && q5.size() != 0) begin
        chk_res("result5", idx5, {3'b000, grant5}, any5, q5[0]);
        if (or5) void'(q5.pop_front());
      end
      if (acc) begin
        e = model(5, {3'b000, req5}, mode5, ptr5, np);
        ptr5 = np;
        q5.push_back(e);
      end
    end
  end

  // One cycle of stimulus on instance s (0: N=8, 1: N=5); the other idles.
  task automatic drv(input int s, input logic [7:0] r, input logic m,
                     input logic iv, input logic ordy);
    @(posedge clk);
    #1;
    if (s == 0) begin
      req8 = r; mode8 = m; iv8 = iv; or8 = ordy;
      iv5 = 1'b0; or5 = 1'b1;
    end else begin
      req5 = r[4:0]; mode5 = m; iv5 = iv; or5 = ordy;
      iv8 = 1'b0; or8 = 1'b1;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drv(0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    req8 = '0; mode8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
    req5 = '0; mode5 = 1'b0; iv5 = 1'b0; or5 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid8", int'(ov8), 0);
    chk("rst_idx8", int'(idx8), 0);
    chk("rst_grant8", int'(grant8), 0);
    chk("rst_any8", int'(any8), 0);
    chk("rst_in_ready8", int'(ir8), 1);
    chk("rst_out_valid5", int'(ov5), 0);
    rst_n = 1'b1;

    // Fixed priority.
    drv(0, 8'h81, 1'b0, 1'b1, 1'b1);
    drv(0, 8'h26, 1'b0, 1'b1, 1'b1);
    drv(0, 8'h01, 1'b0, 1'b1, 1'b1);
    idle(1);
    // Round-robin over a full vector, including the wrap.
    for (int i = 0; i < 9; i++) drv(0, 8'hFF, 1'b1, 1'b1, 1'b1);
    idle(1);
    // Sparse round-robin, a fixed-mode interlude, then round-robin resumes.
    for (int i = 0; i < 3; i++) drv(0, 8'h84, 1'b1, 1'b1, 1'b1);
    drv(0, 8'h84, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) drv(0, 8'h84, 1'b1, 1'b1, 1'b1);
    idle(1);
    // Back-pressure with changing req, then consume and accept together.
    drv(0, 8'h10, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drv(0, 8'($urandom), 1'b0, 1'b1, 1'b0);
    drv(0, 8'h02, 1'b0, 1'b1, 1'b1);
    idle(2);
    // N=5: zero request, then round-robin wrap on a non-power-of-two size.
    drv(1, 8'h00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) drv(1, 8'h1F, 1'b1, 1'b1, 1'b1);
    idle(2);

    // Reset during a stall: outputs clear at once, model restarts.
    drv(0, 8'h10, 1'b1, 1'b1, 1'b1);
    drv(0, 8'h33, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid8", int'(ov8), 0);
    chk("async_rst_grant8", int'(grant8), 0);
    chk("async_rst_in_ready8", int'(ir8), 1);
    q8.delete(); q5.delete();
    ptr8 = 7; ptr5 = 4;
    iv8 = 1'b0; or8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv(0, 8'hFF, 1'b1, 1'b1, 1'b1);
    idle(2);

    // Random traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      drv(int'($urandom_range(0, 1)), r, 1'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) < 7);
    end
    idle(3);
    chk("drain8", q8.size(), 0);
    chk("drain5", q5.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
